// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: opcode encodings and the
// fetch unit's state type.
package mips_pkg;

    // Primary opcodes seen in instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Fetch sequencing: one instruction in flight at a time
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit
// (master) and the instruction memory (slave).
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, BEQ target or (with
// FETCH_JUMP_EN defined) J target. All arithmetic wraps modulo 2^ADDR_W.
module pc_next_logic
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    input  logic              branch,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] branch_target;
    logic              taken;

    assign pc_plus4      = pc + ADDR_W'(4);
    assign branch_offset = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;
    assign taken         = branch & alu_zero;

`ifdef FETCH_JUMP_EN
    logic              is_jump;
    logic [ADDR_W-1:0] jump_target;

    assign is_jump     = (instr[31:26] == OP_J);
    assign jump_target = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};

    // Jump wins over a taken branch; otherwise branch or fall through
    always_comb begin
        next_pc = pc_plus4;
        if (is_jump) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end
    end
`else
    // Opcode and jump-index bits are not needed without the jump path
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31:16];

    // Branch target when taken, otherwise the next sequential word
    always_comb begin
        next_pc = pc_plus4;
        if (taken) begin
            next_pc = branch_target;
        end
    end
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch unit: holds the PC, fetches one instruction at a
// time over the imem req/ack bus, latches it for the decoder and datapath,
// and advances the PC when the datapath retires the instruction.
// Optional jump support is enabled by defining FETCH_JUMP_EN.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   bus,
    input  logic                 exec_ready,
    input  logic                 branch,
    input  logic                 alu_zero,
    output logic [DATA_W-1:0]    instr,
    output logic [5:0]           opcode,
    output logic                 instr_valid,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    pc_plus4
);

    fetch_state_t      state;
    logic              fetch_req;
    logic [ADDR_W-1:0] next_pc;

    pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc       (pc),
        .instr    (instr[31:0]),
        .branch   (branch),
        .alu_zero (alu_zero),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    // The address is the PC itself, so it cannot move while a request waits
    assign bus.imem_req  = fetch_req;
    assign bus.imem_addr = pc;
    assign opcode        = instr[31:26];

    // Fetch sequencer with PC and instruction registers; every output here
    // is registered, and acks outside FETCH or exec_ready outside EXEC
    // simply fall through the case without effect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_req   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    fetch_req <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr       <= bus.imem_rdata;
                        instr_valid <= 1'b1;
                        fetch_req   <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_ready) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        fetch_req   <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    fetch_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. A second instance with
// RESET_PC = 0xFFFFFFFC covers PC wrap-around. Jump expectations follow
// FETCH_JUMP_EN.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exec_ready;
    logic        branch;
    logic        alu_zero;

    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic [31:0] instr_w;
    logic [5:0]  opcode_w;
    logic        instr_valid_w;
    logic [31:0] pc_w;
    logic [31:0] pc_plus4_w;

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_w ();

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .exec_ready  (exec_ready),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    instr_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_w),
        .exec_ready  (exec_ready),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .instr       (instr_w),
        .opcode      (opcode_w),
        .instr_valid (instr_valid_w),
        .pc          (pc_w),
        .pc_plus4    (pc_plus4_w)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // From FETCH: ack with word, then retire it with the given branch inputs
    task automatic fetch_exec(input logic [31:0] word, input logic br, input logic zero);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        tick();
        bus.imem_ack   = 1'b0;
        exec_ready     = 1'b1;
        branch         = br;
        alu_zero       = zero;
        tick();
        exec_ready     = 1'b0;
        branch         = 1'b0;
        alu_zero       = 1'b0;
    endtask

    // Directed sequence
    initial begin
        rst_n            = 1'b0;
        exec_ready       = 1'b0;
        branch           = 1'b0;
        alu_zero         = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = 32'h0;
        bus_w.imem_ack   = 1'b0;
        bus_w.imem_rdata = 32'h0;

        // Reset held for 3 cycles
        tick(); tick(); tick();
        check_output("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        check_output("rst_valid", {31'b0, instr_valid},  32'd0);
        check_output("rst_pc",    pc,                    32'h0);
        check_output("rst_instr", instr,                 32'h0);

        // Startup: IDLE cycle then FETCH at address 0
        rst_n = 1'b1;
        check_output("start_c1_req",   {31'b0, bus.imem_req}, 32'd0);
        check_output("start_c1_valid", {31'b0, instr_valid},  32'd0);
        tick();
        check_output("start_c2_req",   {31'b0, bus.imem_req}, 32'd1);
        check_output("start_c2_addr",  bus.imem_addr,         32'h0);
        check_output("start_c2_valid", {31'b0, instr_valid},  32'd0);

        // Sequential: LW acked in first FETCH cycle
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h8C08_0004;
        tick();
        bus.imem_ack   = 1'b0;
        check_output("seq_valid",  {31'b0, instr_valid},  32'd1);
        check_output("seq_opcode", {26'b0, opcode},       32'h23);
        check_output("seq_instr",  instr,                 32'h8C08_0004);
        check_output("seq_req",    {31'b0, bus.imem_req}, 32'd0);
        tick(); tick();
        check_output("seq_hold_valid", {31'b0, instr_valid}, 32'd1);
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        check_output("seq_next_addr",  bus.imem_addr,         32'h4);
        check_output("seq_next_req",   {31'b0, bus.imem_req}, 32'd1);
        check_output("seq_next_valid", {31'b0, instr_valid},  32'd0);
        check_output("seq_pc_plus4",   pc_plus4,              32'h8);

        // Slow memory: five cycles without ack
        bus.imem_rdata = 32'h2008_0005;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("slow_req",  {31'b0, bus.imem_req}, 32'd1);
            check_output("slow_addr", bus.imem_addr,         32'h4);
        end
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        check_output("slow_valid", {31'b0, instr_valid}, 32'd1);
        check_output("slow_instr", instr,                32'h2008_0005);

        // Ack while in EXEC must not disturb the instruction register
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack   = 1'b0;
        check_output("exec_ack_ignored", instr, 32'h2008_0005);
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        check_output("pc_after_slow", pc, 32'h8);

        // Walk to 0x10 and take a BEQ with imm = -4
        fetch_exec(32'h0000_0020, 1'b0, 1'b0);
        fetch_exec(32'h0000_0020, 1'b0, 1'b0);
        check_output("pc_at_10", pc, 32'h10);
        fetch_exec(32'h1000_FFFC, 1'b1, 1'b1);
        check_output("beq_taken_addr", bus.imem_addr, 32'h4);

        // Back to 0x10, same BEQ not taken
        fetch_exec(32'h0000_0020, 1'b0, 1'b0);
        fetch_exec(32'h0000_0020, 1'b0, 1'b0);
        fetch_exec(32'h0000_0020, 1'b0, 1'b0);
        fetch_exec(32'h1000_FFFC, 1'b1, 1'b0);
        check_output("beq_not_taken_addr", bus.imem_addr, 32'h14);

        // Forward BEQ 0x14 -> 0x40, then J at 0x40
        fetch_exec(32'h1000_000A, 1'b1, 1'b1);
        check_output("beq_fwd_addr", bus.imem_addr, 32'h40);
        fetch_exec(32'h0800_0100, 1'b0, 1'b0);
`ifdef FETCH_JUMP_EN
        check_output("jump_addr", bus.imem_addr, 32'h400);
`else
        check_output("jump_addr", bus.imem_addr, 32'h44);
`endif

        // Reset during FETCH with a pending ack
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.imem_ack   = 1'b0;
        check_output("midrst_instr", instr,                 32'h0);
        check_output("midrst_pc",    pc,                    32'h0);
        check_output("midrst_req",   {31'b0, bus.imem_req}, 32'd0);
        check_output("midrst_valid", {31'b0, instr_valid},  32'd0);
        rst_n = 1'b1;
        tick();

        // Wrap instance: PC 0xFFFFFFFC rolls over to 0
        check_output("wrap_req",    {31'b0, bus_w.imem_req}, 32'd1);
        check_output("wrap_addr",   bus_w.imem_addr,         32'hFFFF_FFFC);
        check_output("wrap_plus4",  pc_plus4_w,              32'h0);
        bus_w.imem_ack   = 1'b1;
        bus_w.imem_rdata = 32'h8C08_0004;
        tick();
        bus_w.imem_ack   = 1'b0;
        check_output("wrap_valid", {31'b0, instr_valid_w}, 32'd1);
        exec_ready = 1'b1;
        tick();
        exec_ready = 1'b0;
        check_output("wrap_next_addr", bus_w.imem_addr, 32'h0);

        // exec_ready seen by the main instance while in FETCH is ignored
        check_output("fetch_ready_ignored_pc",  pc,                    32'h0);
        check_output("fetch_ready_ignored_req", {31'b0, bus.imem_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
